// File: rtl/spi_controller_if.sv
// Command handshake between the config/test logic (master) and spi_controller (slave).
interface spi_controller_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;

  modport master (output cmd_valid, cmd_wr, cmd_addr, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_wr, cmd_addr, cmd_data, output cmd_ready);
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 write-only controller: serialises {wr, addr[6:0], data[7:0]} MSB first on sclk/ncs/copi.
// Define SPI_CTRL_CMD_QUEUE_EN to place a 2-entry command FIFO in front of the FSM.
module spi_controller #(
  parameter int CLK_DIV  = 5,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int GAP      = 4
) (
  input  logic             clk,
  input  logic             rst,
  spi_controller_if.slave  cmd,
  output logic             sclk,
  output logic             ncs,
  output logic             copi,
  output logic             busy,
  output logic             done
);

  if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_clk_div
    $fatal(1, "spi_controller: CLK_DIV must be in 4..255");
  end
  if (GAP < 4 || GAP > 255) begin : g_bad_gap
    $fatal(1, "spi_controller: GAP must be in 4..255");
  end
  if (CS_SETUP < 1 || CS_SETUP > 255 || CS_HOLD < 1 || CS_HOLD > 255) begin : g_bad_cs
    $fatal(1, "spi_controller: CS_SETUP and CS_HOLD must be in 1..255");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HI,
    ST_LO,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Terminal values of the phase counter for each timed state.
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP - 1);

  state_t      r_state, w_state_next;
  logic [7:0]  r_cnt, w_cnt_next;
  logic [3:0]  r_bit, w_bit_next;
  logic [15:0] r_shift, w_shift_next;
  logic        r_copi, w_copi_next;
  logic        r_sclk, w_sclk_next;
  logic        r_ncs, w_ncs_next;
  logic        r_done, w_done_next;
  logic        r_busy, w_busy_next;
  logic        r_cmd_ready, w_ready_next;

  logic        w_cmd_avail;
  logic [15:0] w_cmd_frame;

`ifdef SPI_CTRL_CMD_QUEUE_EN
  logic [15:0] r_fifo [2];
  logic [1:0]  r_fifo_cnt, w_fifo_cnt_next;
  logic [15:0] w_frame_in;
  logic        w_push, w_pop, w_wr_idx;

  assign w_frame_in      = {cmd.cmd_wr, cmd.cmd_addr, cmd.cmd_data};
  assign w_push          = cmd.cmd_valid && r_cmd_ready;
  assign w_cmd_avail     = (r_fifo_cnt != 2'd0);
  assign w_pop           = (r_state == ST_IDLE) && w_cmd_avail;
  assign w_cmd_frame     = r_fifo[0];
  assign w_fifo_cnt_next = r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
  assign w_wr_idx        = (r_fifo_cnt == 2'd2) || ((r_fifo_cnt == 2'd1) && !w_pop);

  // Full is still ready when the FSM will be idle next cycle: that pop frees a slot.
  assign w_ready_next = (w_fifo_cnt_next != 2'd2) || (w_state_next == ST_IDLE);
  assign w_busy_next  = (w_state_next != ST_IDLE) || (w_fifo_cnt_next != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fifo_cnt <= 2'd0;
    else     r_fifo_cnt <= w_fifo_cnt_next;
  end

  // NOTE: FIFO storage is deliberately not reset; the count alone marks which entries are live.
  always_ff @(posedge clk) begin
    if (w_pop)  r_fifo[0]        <= r_fifo[1];
    if (w_push) r_fifo[w_wr_idx] <= w_frame_in;
  end
`else
  assign w_cmd_avail  = cmd.cmd_valid && r_cmd_ready;
  assign w_cmd_frame  = {cmd.cmd_wr, cmd.cmd_addr, cmd.cmd_data};
  assign w_ready_next = (w_state_next == ST_IDLE);
  assign w_busy_next  = (w_state_next != ST_IDLE);
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 8'd1;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_copi_next  = r_copi;
    w_done_next  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_next = 8'd0;
        if (w_cmd_avail) begin
          w_state_next = ST_SETUP;
          w_shift_next = w_cmd_frame;
          w_copi_next  = w_cmd_frame[15];
          w_bit_next   = 4'd15;
        end
      end
      ST_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_state_next = ST_HI;
          w_cnt_next   = 8'd0;
        end
      end
      ST_HI: begin
        if (r_cnt == DIV_LAST) begin
          w_state_next = ST_LO;
          w_cnt_next   = 8'd0;
          // copi only moves together with the falling sclk, a full half-period from any rise.
          if (r_bit != 4'd0) begin
            w_copi_next  = r_shift[14];
            w_shift_next = {r_shift[14:0], 1'b0};
          end
        end
      end
      ST_LO: begin
        if (r_cnt == DIV_LAST) begin
          w_cnt_next = 8'd0;
          if (r_bit == 4'd0) begin
            w_state_next = ST_HOLD;
          end else begin
            w_state_next = ST_HI;
            w_bit_next   = r_bit - 4'd1;
          end
        end
      end
      ST_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_next = ST_GAP;
          w_cnt_next   = 8'd0;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 8'd0;
          w_copi_next  = 1'b0;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 8'd0;
      end
    endcase

    w_sclk_next = (w_state_next == ST_HI);
    w_ncs_next  = (w_state_next == ST_IDLE) || (w_state_next == ST_GAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_bit       <= 4'd0;
      r_shift     <= 16'd0;
      r_copi      <= 1'b0;
      r_sclk      <= 1'b0;
      r_ncs       <= 1'b1;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_bit       <= w_bit_next;
      r_shift     <= w_shift_next;
      r_copi      <= w_copi_next;
      r_sclk      <= w_sclk_next;
      r_ncs       <= w_ncs_next;
      r_done      <= w_done_next;
      r_busy      <= w_busy_next;
      r_cmd_ready <= w_ready_next;
    end
  end

  assign cmd.cmd_ready = r_cmd_ready;
  assign sclk          = r_sclk;
  assign ncs           = r_ncs;
  assign copi          = r_copi;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: drivers queue expected frames/accept times, a link monitor checks them.
`timescale 1ns/1ps
module tb_spi_controller;

  localparam int CLK_DIV = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk, ncs, copi, busy, done;

  spi_controller_if cmd_if ();

  spi_controller #(
    .CLK_DIV  (5),
    .CS_SETUP (4),
    .CS_HOLD  (4),
    .GAP      (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .cmd  (cmd_if),
    .sclk (sclk),
    .ncs  (ncs),
    .copi (copi),
    .busy (busy),
    .done (done)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] exp_q [$];
  int          acc_q [$];
  logic [7:0]  regs [128];
  int          last_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Link monitor + register-peripheral model, sampling on the falling clk edge.
  initial begin : monitor
    logic        prev_ncs, prev_sclk, prev_copi, prev_done;
    logic        active, seen_frame, stable;
    logic [15:0] word, e;
    int          rises, low_cnt, high_run, last_chg, last_rise, a;
    prev_ncs = 1'b1; prev_sclk = 1'b0; prev_copi = 1'b0; prev_done = 1'b0;
    active = 1'b0; seen_frame = 1'b0; stable = 1'b1; word = '0; e = '0;
    rises = 0; low_cnt = 0; high_run = 0; last_chg = -1000; last_rise = -1000; a = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active     = 1'b0;
        seen_frame = 1'b0;
        high_run   = 0;
        prev_ncs   = 1'b1;
        prev_sclk  = 1'b0;
        prev_copi  = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (!ncs) begin
          if (prev_ncs) begin
            if (seen_frame) begin
              check("ncs_high_gap_min", 32'(high_run >= 5), 32'd1);
              last_gap = high_run;
            end
            active = 1'b1; rises = 0; low_cnt = 0; word = '0; stable = 1'b1;
            last_chg = -1000; last_rise = -1000;
          end else if (copi !== prev_copi) begin
            if (cyc - last_rise < CLK_DIV) stable = 1'b0;
            last_chg = cyc;
          end
          low_cnt++;
          if (sclk && !prev_sclk) begin
            if (cyc - last_chg < CLK_DIV) stable = 1'b0;
            word      = {word[14:0], copi};
            rises++;
            last_rise = cyc;
          end
          high_run = 0;
        end else begin
          high_run++;
          if (!prev_ncs && active) begin
            check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("frame_bits", 32'(word), 32'(e));
              check("sclk_rises", 32'(rises), 32'd16);
              check("ncs_low_cycles", 32'(low_cnt), 32'd168);
              check("copi_stable", 32'(stable), 32'd1);
            end
            if (rises == 16 && word[15]) regs[word[14:8]] = word[7:0];
            active     = 1'b0;
            seen_frame = 1'b1;
          end
        end
        if (done) begin
          check("done_single_cycle", 32'(prev_done), 32'd0);
          check("done_expected", 32'(acc_q.size() != 0), 32'd1);
          if (acc_q.size() != 0) begin
            a = acc_q.pop_front();
            check("accept_to_done", 32'(cyc - a), 32'd172);
          end
        end
        prev_ncs  = ncs;
        prev_sclk = sclk;
        prev_copi = copi;
        prev_done = done;
      end
    end
  end

  // Offer a command from a negedge; returns 1 ns after the accepting posedge.
  task automatic send(input logic wr, input logic [6:0] addr, input logic [7:0] data,
                      input logic [15:0] exp_frame);
    int t;
    t = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_wr    = wr;
    cmd_if.cmd_addr  = addr;
    cmd_if.cmd_data  = data;
    while (cmd_if.cmd_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("accept_in_time", 32'(cmd_if.cmd_ready === 1'b1), 32'd1);
    exp_q.push_back(exp_frame);
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("idle_in_time", 32'(!busy), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got no completion, required finish within 5 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic ok, p;
    int   n, t;
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_wr    = 1'b0;
    cmd_if.cmd_addr  = 7'h00;
    cmd_if.cmd_data  = 8'h00;

    // Reset state, then cmd_ready on the first edge after release.
    repeat (3) @(negedge clk);
    check("reset_sclk",  32'(sclk), 32'd0);
    check("reset_ncs",   32'(ncs), 32'd1);
    check("reset_copi",  32'(copi), 32'd0);
    check("reset_ready", 32'(cmd_if.cmd_ready), 32'd0);
    check("reset_busy",  32'(busy), 32'd0);
    check("reset_done",  32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(cmd_if.cmd_ready), 32'd1);

    // Single write.
    send(1'b1, 7'h04, 8'h80, 16'h8480);
    wait_idle();

    // Back-to-back loopback writes.
    @(negedge clk);
    send(1'b1, 7'h00, 8'hA5, 16'h80A5);
    @(negedge clk);
    send(1'b1, 7'h04, 8'h3C, 16'h843C);
    wait_idle();
    check("b2b_ncs_high_cycles", 32'(last_gap), 32'd5);
    check("reg_en_reg_out_7_0", 32'(regs[0]), 32'hA5);
    check("reg_pwm_duty_cycle", 32'(regs[4]), 32'h3C);

    // Valid held with changing data during a frame: all ignored.
    @(negedge clk);
    send(1'b1, 7'h10, 8'h01, 16'h9001);
    ok = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_wr    = i[0];
      cmd_if.cmd_addr  = 7'(i);
      cmd_if.cmd_data  = 8'(i * 3);
      if (cmd_if.cmd_ready !== 1'b0) ok = 1'b0;
    end
    check("ready_low_in_frame", 32'(ok), 32'd1);
    cmd_if.cmd_valid = 1'b0;
    wait_idle();

    // Reset at the 9th sclk rise, then a clean frame.
    @(negedge clk);
    send(1'b1, 7'h00, 8'h11, 16'h8011);
    n = 0; t = 0; p = 1'b0;
    while (n < 9 && t < 500) begin
      @(negedge clk);
      if (sclk && !p) n++;
      p = sclk;
      t++;
    end
    check("reached_rise9", 32'(n), 32'd9);
    check("sclk_high_at_rise9", 32'(sclk), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("abort_ncs_async",  32'(ncs), 32'd1);
    check("abort_sclk_async", 32'(sclk), 32'd0);
    check("abort_busy",       32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(1'b1, 7'h01, 8'h55, 16'h8155);
    wait_idle();
    check("reg0_kept_after_abort", 32'(regs[0]), 32'hA5);
    check("reg1_written", 32'(regs[1]), 32'h55);

    // Read frame: shifted verbatim, no register change.
    @(negedge clk);
    send(1'b0, 7'h02, 8'h77, 16'h0277);
    wait_idle();
    check("reg2_unchanged", 32'(regs[2]), 32'h00);
    check("reg4_unchanged", 32'(regs[4]), 32'h3C);

    repeat (20) @(negedge clk);
    check("frames_outstanding", 32'(exp_q.size()), 32'd0);
    check("dones_outstanding",  32'(acc_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
